flow_lookup_arbiter: RTL and testbench

- Shares one flow-table lookup engine between NUM_REQ flow key generator instances, one per RX path.
- Arbitrates round-robin and forwards the winning 104-bit 5-tuple key to the engine.
- Tracks the single outstanding lookup and routes the hit/result response back to the requester that owns it.
- Sits between the flow_key_gen outputs and the flow table.

---
 rtl/flow_lookup_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_flow_lookup_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_lookup_arbiter.sv
// flow_lookup_arbiter: shares one flow-table lookup engine between
// NUM_REQ flow key generators (one per RX path).
//
// A round-robin arbiter picks one valid requester and forwards its
// 104-bit 5-tuple key to the engine. The arbiter then tracks that
// single outstanding lookup and routes the hit/result back to the
// requester that owns it as a one-cycle strobe.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid       per-requester key valid
//   req_ready       per-requester accept (one-hot, combinational in IDLE)
//   req_key         packed keys, requester i at [i*KEY_W +: KEY_W]
//   rsp_valid       per-requester response strobe (one-hot, 1 cycle)
//   rsp_hit         shared lookup hit, qualified by rsp_valid
//   rsp_result      shared lookup result, qualified by rsp_valid
//   rsp_error       shared timeout flag, qualified by rsp_valid
//   lu_valid        key valid to the lookup engine
//   lu_ready        engine accepts key
//   lu_key          key to the lookup engine
//   lu_rsp_valid    engine response strobe
//   lu_rsp_hit      engine hit
//   lu_rsp_result   engine result
//   busy            lookup in progress
//   grant_id        current/last granted requester
//
// Optional feature macro: FLOW_LOOKUP_TIMEOUT_EN
//   When defined, a watchdog ends a WAIT that lasts TIMEOUT_CYCLES
//   cycles with an error response (hit=0, result=0, error=1).
//   When undefined, WAIT holds until the engine answers and
//   rsp_error is tied to 0.

module flow_lookup_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int KEY_W          = 104,
    parameter int RESULT_W       = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*KEY_W-1:0]   req_key,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic                       rsp_hit,
    output logic [RESULT_W-1:0]        rsp_result,
    output logic                       rsp_error,
    output logic                       lu_valid,
    input  logic                       lu_ready,
    output logic [KEY_W-1:0]           lu_key,
    input  logic                       lu_rsp_valid,
    input  logic                       lu_rsp_hit,
    input  logic [RESULT_W-1:0]        lu_rsp_result,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Elaboration-time guard on the supported configuration range.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("flow_lookup_arbiter: unsupported NUM_REQ/TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant;
    logic [KEY_W-1:0]    r_lu_key;
    logic                r_hit;
    logic [RESULT_W-1:0] r_result;

    logic                w_any;
    logic [IDX_W-1:0]    w_win;
    logic [KEY_W-1:0]    w_sel_key;
    logic                w_accept;
    logic                w_timeout;

    // ------------------------------------------------------------
    // Round-robin pick: first valid requester at or after r_rr_ptr,
    // wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
    // ------------------------------------------------------------
    always_comb begin
        logic [IDX_W:0]   v_sum;
        logic [IDX_W-1:0] v_idx;
        w_any = 1'b0;
        w_win = '0;
        v_sum = '0;
        v_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (v_sum >= (IDX_W+1)'(NUM_REQ)) begin
                v_sum = v_sum - (IDX_W+1)'(NUM_REQ);
            end
            v_idx = v_sum[IDX_W-1:0];
            if (!w_any && req_valid[v_idx]) begin
                w_any = 1'b1;
                w_win = v_idx;
            end
        end
    end

    always_comb begin
        w_sel_key = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_sel_key = req_key[i*KEY_W +: KEY_W];
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_any;

    // ------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (lu_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lu_rsp_valid || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_accept && (w_win == IDX_W'(i));
            rsp_valid[i] = (r_state == S_RESP) &&
                           (r_grant == IDX_W'(i));
        end
        lu_valid = (r_state == S_ISSUE);
        busy     = (r_state != S_IDLE);
    end

    assign lu_key     = r_lu_key;
    assign grant_id   = r_grant;
    assign rsp_hit    = r_hit;
    assign rsp_result = r_result;

    // ------------------------------------------------------------
    // Grant bookkeeping and captured key
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_lu_key <= '0;
        end else if (w_accept) begin
            r_lu_key <= w_sel_key;
            r_grant  <= w_win;
            r_rr_ptr <= (w_win == IDX_W'(NUM_REQ - 1)) ?
                        '0 : w_win + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------
    // Response capture; values hold until the next lookup completes.
    // An engine response takes priority over a same-cycle timeout.
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit    <= 1'b0;
            r_result <= '0;
        end else if (r_state == S_WAIT) begin
            if (lu_rsp_valid) begin
                r_hit    <= lu_rsp_hit;
                r_result <= lu_rsp_result;
            end else if (w_timeout) begin
                r_hit    <= 1'b0;
                r_result <= '0;
            end
        end
    end

`ifdef FLOW_LOOKUP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;

    // Counts WAIT cycles already spent; zero on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle with no response.
    assign w_timeout = (r_state == S_WAIT) && !lu_rsp_valid &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_WAIT && lu_rsp_valid) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign rsp_error = r_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_flow_lookup_arbiter.sv
// Self-checking bench for flow_lookup_arbiter: directed table,
// hand-written corner sequences and randomized lookups.

module tb_flow_lookup_arbiter;

    localparam int NREQ = 4;
    localparam int KW   = 104;
    localparam int RW   = 16;
`ifdef FLOW_LOOKUP_TIMEOUT_EN
    localparam int TO_LIM = 8;
`else
    localparam int TO_LIM = 255;
`endif

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*KW-1:0]   req_key;
    logic [NREQ-1:0]      rsp_valid;
    logic                 rsp_hit;
    logic [RW-1:0]        rsp_result;
    logic                 rsp_error;
    logic                 lu_valid;
    logic                 lu_ready;
    logic [KW-1:0]        lu_key;
    logic                 lu_rsp_valid;
    logic                 lu_rsp_hit;
    logic [RW-1:0]        lu_rsp_result;
    logic                 busy;
    logic [1:0]           grant_id;

    flow_lookup_arbiter #(
        .NUM_REQ        (NREQ),
        .KEY_W          (KW),
        .RESULT_W       (RW),
        .TIMEOUT_CYCLES (TO_LIM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_key       (req_key),
        .rsp_valid     (rsp_valid),
        .rsp_hit       (rsp_hit),
        .rsp_result    (rsp_result),
        .rsp_error     (rsp_error),
        .lu_valid      (lu_valid),
        .lu_ready      (lu_ready),
        .lu_key        (lu_key),
        .lu_rsp_valid  (lu_rsp_valid),
        .lu_rsp_hit    (lu_rsp_hit),
        .lu_rsp_result (lu_rsp_result),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: next round-robin start and last delivered response.
    int            rr;
    logic          last_hit;
    logic [RW-1:0] last_res;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KW-1:0] mk_key(input int i, input int n);
        logic [31:0] dip;
        logic [15:0] sp;
        dip = 32'hC0A80104 + 32'(n);
        sp  = 16'hD200 + 16'(i);
        return {8'h06, 32'hC0A80101, dip, sp, 16'h5006};
    endfunction

    function automatic logic [NREQ*KW-1:0] mk_keys(input int n);
        logic [NREQ*KW-1:0] k;
        k = '0;
        for (int i = 0; i < NREQ; i++) k[i*KW +: KW] = mk_key(i, n);
        return k;
    endfunction

    function automatic logic [NREQ*KW-1:0] rand_keys();
        logic [NREQ*KW-1:0] k;
        logic [127:0]       t;
        k = '0;
        for (int i = 0; i < NREQ; i++) begin
            t = {$urandom, $urandom, $urandom, $urandom};
            k[i*KW +: KW] = t[KW-1:0];
        end
        return k;
    endfunction

    // Spec rule: first valid index searching upward from start, modulo NREQ.
    function automatic int rr_pick(input logic [NREQ-1:0] m, input int start);
        logic [NREQ-1:0] b;
        for (int k = 0; k < NREQ; k++) begin
            b = m >> ((start + k) % NREQ);
            if (b[0]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_hit"}, rsp_hit, 0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_error"}, rsp_error, 0);
        chk({tag, "_lu_valid"}, lu_valid, 0);
        chk({tag, "_lu_key"}, lu_key, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
    endtask

    // One full lookup: grant, issue (with backpressure), wait, respond.
    // rsp_wait is the number of cycles after the lu handshake at which
    // the engine answers; silent means the engine never answers.
    task automatic run_txn(input string nm,
                           input logic [NREQ-1:0] mask,
                           input logic [NREQ*KW-1:0] keys,
                           input int g, input int lu_wait,
                           input int rsp_wait, input bit silent,
                           input bit spur, input logic hit,
                           input logic [RW-1:0] res);
        logic [KW-1:0]   k;
        logic [NREQ-1:0] oh;
        int              n;
        k     = keys[g*KW +: KW];
        oh    = '0;
        oh[g] = 1'b1;
        n     = silent ? TO_LIM : rsp_wait;

        tick();
        req_valid    = mask;
        req_key      = keys;
        lu_ready     = 1'b0;
        lu_rsp_valid = 1'b0;
        #4;
        chk({nm, "_grant"}, req_ready, oh);
        chk({nm, "_idle_busy"}, busy, 0);
        chk({nm, "_hold"}, {rsp_hit, rsp_result}, {last_hit, last_res});

        for (int c = 0; c <= lu_wait; c++) begin
            tick();
            lu_ready      = (c == lu_wait);
            lu_rsp_valid  = spur;
            lu_rsp_hit    = ~hit;
            lu_rsp_result = ~res;
            #4;
            chk({nm, "_lu_valid"}, lu_valid, 1);
            chk({nm, "_lu_key"}, lu_key, k);
            chk({nm, "_gid"}, grant_id, g);
            chk({nm, "_iss_ready"}, req_ready, 0);
            chk({nm, "_iss_rsp"}, rsp_valid, 0);
        end

        for (int c = 1; c <= n; c++) begin
            tick();
            lu_ready      = 1'b0;
            lu_rsp_valid  = !silent && (c == n);
            lu_rsp_hit    = hit;
            lu_rsp_result = res;
            #4;
            chk({nm, "_wait_luv"}, lu_valid, 0);
            chk({nm, "_wait_rsp"}, rsp_valid, 0);
            chk({nm, "_wait_ready"}, req_ready, 0);
            chk({nm, "_wait_busy"}, busy, 1);
        end

        tick();
        lu_rsp_valid  = 1'b0;
        lu_rsp_hit    = $urandom_range(0, 1) != 0;
        lu_rsp_result = RW'($urandom);
        #4;
        last_hit = silent ? 1'b0 : hit;
        last_res = silent ? '0 : res;
        chk({nm, "_rsp_valid"}, rsp_valid, oh);
        chk({nm, "_rsp_hit"}, rsp_hit, last_hit);
        chk({nm, "_rsp_result"}, rsp_result, last_res);
        chk({nm, "_rsp_error"}, rsp_error, silent);
        chk({nm, "_rsp_ready"}, req_ready, 0);
    endtask

    typedef struct {
        logic [NREQ-1:0] mask;
        int              g;
        int              lu_wait;
        int              rsp_wait;
        bit              spur;
        logic            hit;
        logic [RW-1:0]   res;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{4'b0001, 0, 0,  2, 1'b0, 1'b1, 16'h002A};
        tbl[1]  = '{4'b1111, 1, 0,  3, 1'b0, 1'b0, 16'h0101};
        tbl[2]  = '{4'b1111, 2, 0,  3, 1'b0, 1'b1, 16'h0202};
        tbl[3]  = '{4'b1111, 3, 0,  3, 1'b0, 1'b1, 16'h0303};
        tbl[4]  = '{4'b1111, 0, 0,  3, 1'b0, 1'b0, 16'h0404};
        tbl[5]  = '{4'b1111, 1, 10, 1, 1'b0, 1'b1, 16'h0505};
        tbl[6]  = '{4'b0001, 0, 1,  2, 1'b1, 1'b1, 16'h0606};
        tbl[7]  = '{4'b0001, 0, 0,  1, 1'b1, 1'b0, 16'hBEEF};
        tbl[8]  = '{4'b0101, 2, 0,  5, 1'b0, 1'b1, 16'h0808};
        tbl[9]  = '{4'b0011, 0, 2,  1, 1'b0, 1'b1, 16'h0909};
        tbl[10] = '{4'b1000, 3, 0,  2, 1'b0, 1'b0, 16'h0A0A};
        tbl[11] = '{4'b0110, 1, 0,  1, 1'b1, 1'b1, 16'h0B0B};
        tbl[12] = '{4'b1010, 3, 1,  3, 1'b0, 1'b1, 16'hFFFF};
        tbl[13] = '{4'b1001, 0, 0,  1, 1'b0, 1'b0, 16'h0000};

        rst           = 1'b1;
        req_valid     = '0;
        req_key       = '0;
        lu_ready      = 1'b0;
        lu_rsp_valid  = 1'b0;
        lu_rsp_hit    = 1'b0;
        lu_rsp_result = '0;
        rr            = 0;
        last_hit      = 1'b0;
        last_res      = '0;

        tick();
        tick();
        #4;
        chk_reset_state("reset");
        tick();
        rst = 1'b0;

        // Spurious engine response while idle.
        tick();
        lu_rsp_valid  = 1'b1;
        lu_rsp_hit    = 1'b1;
        lu_rsp_result = 16'h7777;
        #4;
        chk("idle_spur_rsp", rsp_valid, 0);
        tick();
        lu_rsp_valid = 1'b0;
        #4;
        chk("idle_spur_busy", busy, 0);
        chk("idle_spur_rsp2", rsp_valid, 0);

        // Directed table: grants are hand-derived from reset (rr=0).
        for (int i = 0; i < 14; i++) begin
            run_txn($sformatf("tbl%0d", i), tbl[i].mask, mk_keys(i),
                    tbl[i].g, tbl[i].lu_wait, tbl[i].rsp_wait, 1'b0,
                    tbl[i].spur, tbl[i].hit, tbl[i].res);
            rr = (tbl[i].g + 1) % NREQ;
        end

        // Reset while a lookup is outstanding (requester 1 granted).
        tick();
        req_valid = 4'b0010;
        req_key   = mk_keys(50);
        #4;
        chk("rst_mid_grant", req_ready, 4'b0010);
        tick();
        lu_ready = 1'b1;
        #4;
        chk("rst_mid_issue", lu_valid, 1);
        tick();
        lu_ready  = 1'b0;
        req_valid = '0;
        #4;
        chk("rst_mid_wait", busy, 1);
        tick();
        rst = 1'b1;
        #4;
        tick();
        rst = 1'b0;
        #4;
        chk_reset_state("rst_mid");
        last_hit = 1'b0;
        last_res = '0;
        tick();
        lu_rsp_valid  = 1'b1;
        lu_rsp_hit    = 1'b1;
        lu_rsp_result = 16'h1234;
        #4;
        chk("rst_late_rsp", rsp_valid, 0);
        tick();
        lu_rsp_valid = 1'b0;
        #4;
        chk("rst_late_rsp2", rsp_valid, 0);
        chk("rst_late_busy", busy, 0);
        run_txn("rst_after", 4'b0101, mk_keys(51), 0, 0, 2, 1'b0,
                1'b0, 1'b1, 16'h00C3);
        rr = 1;

`ifdef FLOW_LOOKUP_TIMEOUT_EN
        // Engine never answers, then answers exactly on the limit cycle.
        run_txn("timeout", 4'b0100, mk_keys(60), 2, 0, 0, 1'b1,
                1'b0, 1'b1, 16'h5555);
        rr = 3;
        run_txn("limit_rsp", 4'b0100, mk_keys(61), 2, 1, TO_LIM, 1'b0,
                1'b0, 1'b1, 16'h6666);
        rr = 3;
`endif

        // Randomized lookups against the round-robin rule.
        for (int t = 0; t < 40; t++) begin
            int               g;
            int               gap;
            logic [NREQ-1:0]  m;
            gap = $urandom_range(0, 2);
            for (int c = 0; c < gap; c++) begin
                tick();
                req_valid    = '0;
                lu_rsp_valid = $urandom_range(0, 1) != 0;
                #4;
                chk("rnd_gap_ready", req_ready, 0);
                chk("rnd_gap_rsp", rsp_valid, 0);
                chk("rnd_gap_busy", busy, 0);
            end
            m = NREQ'($urandom_range(1, 15));
            g = rr_pick(m, rr);
            rr = (g + 1) % NREQ;
            run_txn($sformatf("rnd%0d", t), m, rand_keys(), g,
                    $urandom_range(0, 3), $urandom_range(1, 4), 1'b0,
                    $urandom_range(0, 1) != 0,
                    $urandom_range(0, 1) != 0, RW'($urandom));
        end

        tick();
        req_valid = '0;
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
